// File: rtl/mag_comp_pkg.sv
// Shared types for the pipelined magnitude comparator: the partial-result
// encoding carried between stages and the rule that merges slice results.
package mag_comp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } cmp_res_t;

  // Once a more significant slice has decided the order, lower slices cannot change it.
  function automatic cmp_res_t cmp_merge(cmp_res_t prev, cmp_res_t slice_res);
    return (prev == CMP_EQ) ? slice_res : prev;
  endfunction

endpackage

// File: rtl/mag_comp_stage.sv
// One comparator pipeline stage: compares the top S bits of its operands,
// merges with the upstream result and forwards only the lower REM bits.
module mag_comp_stage
  import mag_comp_pkg::*;
#(
  parameter int S   = 4,
  parameter int REM = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  input  cmp_res_t                     in_res,
  input  logic [S+REM-1:0]             a_in,
  input  logic [S+REM-1:0]             b_in,
  output logic                         out_valid,
  output cmp_res_t                     out_res,
  output logic [(REM > 0 ? REM : 1)-1:0] a_rem,
  output logic [(REM > 0 ? REM : 1)-1:0] b_rem
);

  logic [S-1:0] a_slice;
  logic [S-1:0] b_slice;
  cmp_res_t     slice_res;

  assign a_slice = a_in[S+REM-1 -: S];
  assign b_slice = b_in[S+REM-1 -: S];

  // NOTE: default assigned first so every path drives slice_res and no latch is inferred.
  always_comb begin
    slice_res = CMP_EQ;
    if (a_slice > b_slice)      slice_res = CMP_GT;
    else if (a_slice < b_slice) slice_res = CMP_LT;
  end

  // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
  always_ff @(posedge clk) begin
    if (rst)     out_valid <= 1'b0;
    else if (en) out_valid <= in_valid;
  end

  // NOTE: result and operand registers carry no reset; the valid bit qualifies them.
  always_ff @(posedge clk) begin
    if (en) out_res <= cmp_merge(in_res, slice_res);
  end

  if (REM > 0) begin : g_rem
    always_ff @(posedge clk) begin
      if (en) begin
        a_rem <= a_in[REM-1:0];
        b_rem <= b_in[REM-1:0];
      end
    end
  end else begin : g_no_rem
    assign a_rem = '0;
    assign b_rem = '0;
  end

endmodule

// File: rtl/mag_comp_pipe.sv
// Pipelined K-bit magnitude comparator, S bits per stage, signed/unsigned per
// transaction, valid/ready on both sides with one global advance enable.
module mag_comp_pipe
  import mag_comp_pkg::*;
#(
  parameter int K = 8,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         sgn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         gt,
  output logic         eq,
  output logic         lt
);

  localparam int N = K / S;

  if (K < 2 || S < 1 || (K % S) != 0) begin : g_param_check
    $error("mag_comp_pipe: K must be >= 2 and an integer multiple of S");
  end

  logic     en;
  logic [K-1:0] a_adj;
  logic [K-1:0] b_adj;
  cmp_res_t res_last;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign a_adj = {a[K-1] ^ sgn, a[K-2:0]};
  assign b_adj = {b[K-1] ^ sgn, b[K-2:0]};

  for (genvar j = 0; j < N; j++) begin : g_stage
    localparam int W   = K - j * S;
    localparam int REM = W - S;

    logic [W-1:0]                  a_cur;
    logic [W-1:0]                  b_cur;
    logic                          v_cur;
    cmp_res_t                      r_cur;
    logic [(REM > 0 ? REM : 1)-1:0] a_nxt;
    logic [(REM > 0 ? REM : 1)-1:0] b_nxt;
    logic                          v_nxt;
    cmp_res_t                      r_nxt;

    if (j == 0) begin : g_head
      assign a_cur = a_adj;
      assign b_cur = b_adj;
      assign v_cur = in_valid;
      assign r_cur = CMP_EQ;
    end else begin : g_link
      assign a_cur = g_stage[j-1].a_nxt;
      assign b_cur = g_stage[j-1].b_nxt;
      assign v_cur = g_stage[j-1].v_nxt;
      assign r_cur = g_stage[j-1].r_nxt;
    end

    mag_comp_stage #(
      .S   (S),
      .REM (REM)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (v_cur),
      .in_res    (r_cur),
      .a_in      (a_cur),
      .b_in      (b_cur),
      .out_valid (v_nxt),
      .out_res   (r_nxt),
      .a_rem     (a_nxt),
      .b_rem     (b_nxt)
    );
  end

  // The last stage has no operand bits left to forward; its remainder outputs are tied to zero.
  logic unused_tail;
  assign unused_tail = ^{g_stage[N-1].a_nxt, g_stage[N-1].b_nxt};

  assign out_valid = g_stage[N-1].v_nxt;
  assign res_last  = g_stage[N-1].r_nxt;

  assign gt = out_valid && (res_last == CMP_GT);
  assign eq = out_valid && (res_last == CMP_EQ);
  assign lt = out_valid && (res_last == CMP_LT);

endmodule

// File: tb/tb_mag_comp_pipe.sv
// Self-checking bench for mag_comp_pipe: directed vector table, scripted
// stall/reset/bubble sequences, and random streams on three configurations.
module tb_mag_comp_pipe;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sgn;
    logic [2:0] res;   // {gt, eq, lt}
  } vec_t;

  typedef struct {
    int   drv;   // vector index to present, -1 = in_valid low
    logic rdy;
    logic rst;
    int   exp;   // vector index expected on the output, -1 = out_valid low
    logic inr;
  } step_t;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;
  localparam int NV     = 17;
  localparam int NV_STR = 16;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  a, b;
  logic        sgn;
  logic        gt, eq, lt;
  logic        iv_x;
  logic        inr_1, ov_1, gt_1, eq_1, lt_1;
  logic        inr_8, ov_8, gt_8, eq_8, lt_8;
  logic [31:0] a32, b32;

  int checks = 0;
  int errors = 0;

  vec_t  vec [NV];
  step_t scr [12];
  int    scr_len;

  logic [2:0] q_m[$];
  logic [2:0] q_1[$];
  logic [2:0] q_8[$];

  mag_comp_pipe #(.K(8), .S(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .eq(eq), .lt(lt)
  );

  mag_comp_pipe #(.K(8), .S(8)) dut_n1 (
    .clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(inr_1),
    .a(a), .b(b), .sgn(sgn), .out_valid(ov_1), .out_ready(out_ready),
    .gt(gt_1), .eq(eq_1), .lt(lt_1)
  );

  mag_comp_pipe #(.K(32), .S(4)) dut_n8 (
    .clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(inr_8),
    .a(a32), .b(b32), .sgn(sgn), .out_valid(ov_8), .out_ready(out_ready),
    .gt(gt_8), .eq(eq_8), .lt(lt_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx);
    in_valid = 1'b1;
    a        = vec[idx].a;
    b        = vec[idx].b;
    sgn      = vec[idx].sgn;
  endtask

  // Reference: compare the operands as plain integers, sign-extended when sgn=1.
  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y,
                                         input logic s, input int w);
    longint xi, yi;
    xi = longint'(x);
    yi = longint'(y);
    if (s && x[w-1]) xi = xi - (longint'(1) << w);
    if (s && y[w-1]) yi = yi - (longint'(1) << w);
    if (xi > yi)  return R_GT;
    if (xi == yi) return R_EQ;
    return R_LT;
  endfunction

  task automatic run_script(input string tag);
    for (int i = 0; i < scr_len; i++) begin
      tick();
      if (scr[i].exp < 0)
        check($sformatf("%s[%0d] idle out", tag, i), {28'b0, out_valid, gt, eq, lt}, 32'h0);
      else
        check($sformatf("%s[%0d] result", tag, i), {28'b0, out_valid, gt, eq, lt},
              {28'b0, 1'b1, vec[scr[i].exp].res});
      rst       = scr[i].rst;
      out_ready = scr[i].rdy;
      if (scr[i].drv >= 0) drive(scr[i].drv);
      else                 in_valid = 1'b0;
      #1;
      check($sformatf("%s[%0d] in_ready", tag, i), {31'b0, in_ready}, {31'b0, scr[i].inr});
    end
  endtask

  // Output side is scored before input side so each queue stays in transfer order.
  task automatic score();
    if (out_valid && out_ready) begin
      if (q_m.size() == 0) check("main spurious out_valid", {31'b0, out_valid}, 32'h0);
      else check("main random result", {29'b0, gt, eq, lt}, {29'b0, q_m.pop_front()});
    end
    if (ov_1 && out_ready) begin
      if (q_1.size() == 0) check("n1 spurious out_valid", {31'b0, ov_1}, 32'h0);
      else check("n1 random result", {29'b0, gt_1, eq_1, lt_1}, {29'b0, q_1.pop_front()});
    end
    if (ov_8 && out_ready) begin
      if (q_8.size() == 0) check("n8 spurious out_valid", {31'b0, ov_8}, 32'h0);
      else check("n8 random result", {29'b0, gt_8, eq_8, lt_8}, {29'b0, q_8.pop_front()});
    end
    if (!out_valid) check("main idle outputs", {29'b0, gt, eq, lt}, 32'h0);
    if (in_valid && in_ready) q_m.push_back(ref_cmp({24'b0, a}, {24'b0, b}, sgn, 8));
    if (iv_x && inr_1)        q_1.push_back(ref_cmp({24'b0, a}, {24'b0, b}, sgn, 8));
    if (iv_x && inr_8)        q_8.push_back(ref_cmp(a32, b32, sgn, 32));
  endtask

  initial begin
    int lat_m, lat_1, lat_8;

    // sgn alternates across the first NV_STR entries so streaming them exercises per-transaction sign capture.
    vec[0]  = '{8'h35, 8'h34, 1'b0, R_GT};
    vec[1]  = '{8'h80, 8'h7F, 1'b1, R_LT};
    vec[2]  = '{8'h34, 8'h35, 1'b0, R_LT};
    vec[3]  = '{8'hFF, 8'h00, 1'b1, R_LT};
    vec[4]  = '{8'hA5, 8'hA5, 1'b0, R_EQ};
    vec[5]  = '{8'h00, 8'hFF, 1'b1, R_GT};
    vec[6]  = '{8'h80, 8'h7F, 1'b0, R_GT};
    vec[7]  = '{8'hFF, 8'hFF, 1'b1, R_EQ};
    vec[8]  = '{8'hFF, 8'h00, 1'b0, R_GT};
    vec[9]  = '{8'h00, 8'h00, 1'b1, R_EQ};
    vec[10] = '{8'h00, 8'hFF, 1'b0, R_LT};
    vec[11] = '{8'hC0, 8'hBF, 1'b1, R_GT};
    vec[12] = '{8'hFF, 8'hFF, 1'b0, R_EQ};
    vec[13] = '{8'h35, 8'h53, 1'b1, R_LT};
    vec[14] = '{8'h00, 8'h00, 1'b0, R_EQ};
    vec[15] = '{8'h53, 8'h35, 1'b1, R_GT};
    vec[16] = '{8'h01, 8'h00, 1'b0, R_GT};

    rst = 1'b1; in_valid = 1'b0; iv_x = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sgn = 1'b0; a32 = '0; b32 = '0;
    tick();
    tick();
    check("reset main out", {28'b0, out_valid, gt, eq, lt}, 32'h0);
    check("reset n1 out_valid", {31'b0, ov_1}, 32'h0);
    check("reset n8 out_valid", {31'b0, ov_8}, 32'h0);
    check("reset in_ready", {31'b0, in_ready}, 32'h1);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    check("in_ready after reset", {31'b0, in_ready}, 32'h1);

    // Isolated vectors: nothing after one edge, the result after two.
    for (int i = 0; i < NV; i++) begin
      drive(i);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d early valid", i), {31'b0, out_valid}, 32'h0);
      tick();
      check($sformatf("vec%0d valid", i), {31'b0, out_valid}, 32'h1);
      check($sformatf("vec%0d result", i), {29'b0, gt, eq, lt}, {29'b0, vec[i].res});
    end

    // Back-to-back stream: result of entry i is visible two iterations later.
    for (int i = 0; i < NV_STR + 2; i++) begin
      tick();
      if (i >= 2)
        check($sformatf("stream%0d", i - 2), {28'b0, out_valid, gt, eq, lt},
              {28'b0, 1'b1, vec[i-2].res});
      else
        check($sformatf("stream lead%0d", i), {31'b0, out_valid}, 32'h0);
      if (i < NV_STR) drive(i);
      else            in_valid = 1'b0;
    end

    // Backpressure: four transactions, out_ready low for three cycles once a result shows.
    scr[0] = '{0,  1'b1, 1'b0, -1, 1'b1};
    scr[1] = '{1,  1'b1, 1'b0, -1, 1'b1};
    scr[2] = '{2,  1'b0, 1'b0,  0, 1'b0};
    scr[3] = '{2,  1'b0, 1'b0,  0, 1'b0};
    scr[4] = '{2,  1'b0, 1'b0,  0, 1'b0};
    scr[5] = '{2,  1'b1, 1'b0,  0, 1'b1};
    scr[6] = '{3,  1'b1, 1'b0,  1, 1'b1};
    scr[7] = '{-1, 1'b1, 1'b0,  2, 1'b1};
    scr[8] = '{-1, 1'b1, 1'b0,  3, 1'b1};
    scr[9] = '{-1, 1'b1, 1'b0, -1, 1'b1};
    scr_len = 10;
    run_script("stall");

    // Reset mid-flight: the second transaction must never appear; a=1,b=0 follows.
    scr[0] = '{0,  1'b1, 1'b0, -1, 1'b1};
    scr[1] = '{1,  1'b1, 1'b0, -1, 1'b1};
    scr[2] = '{-1, 1'b1, 1'b1,  0, 1'b1};
    scr[3] = '{16, 1'b1, 1'b0, -1, 1'b1};
    scr[4] = '{-1, 1'b1, 1'b0, -1, 1'b1};
    scr[5] = '{-1, 1'b1, 1'b0, 16, 1'b1};
    scr[6] = '{-1, 1'b1, 1'b0, -1, 1'b1};
    scr_len = 7;
    run_script("reset");

    // Bubbles propagate unchanged.
    scr[0] = '{0,  1'b1, 1'b0, -1, 1'b1};
    scr[1] = '{-1, 1'b1, 1'b0, -1, 1'b1};
    scr[2] = '{11, 1'b1, 1'b0,  0, 1'b1};
    scr[3] = '{-1, 1'b1, 1'b0, -1, 1'b1};
    scr[4] = '{-1, 1'b1, 1'b0, 11, 1'b1};
    scr[5] = '{-1, 1'b1, 1'b0, -1, 1'b1};
    scr_len = 6;
    run_script("bubble");

    // Random streams with random backpressure on all three configurations.
    for (int n = 0; n < 10000; n++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      iv_x      = in_valid;
      sgn       = 1'($urandom);
      a         = 8'($urandom);
      a32       = $urandom;
      case ($urandom_range(0, 3))
        0: begin b = a; b32 = a32; end
        1: begin
          b   = a ^ (8'd1 << $urandom_range(0, 7));
          b32 = a32 ^ (32'd1 << $urandom_range(0, 31));
        end
        default: begin b = 8'($urandom); b32 = $urandom; end
      endcase
      #1;
      score();
    end

    for (int n = 0; n < 12; n++) begin
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      iv_x      = 1'b0;
      #1;
      score();
    end
    check("main queue drained", q_m.size(), 32'h0);
    check("n1 queue drained", q_1.size(), 32'h0);
    check("n8 queue drained", q_8.size(), 32'h0);

    // Latency of each configuration from a single accept into an empty pipeline.
    lat_m = 0; lat_1 = 0; lat_8 = 0;
    a = 8'h01; b = 8'h00; a32 = 32'h1; b32 = 32'h0; sgn = 1'b0;
    in_valid = 1'b1; iv_x = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin
        in_valid = 1'b0;
        iv_x     = 1'b0;
      end
      if (lat_m == 0 && out_valid) lat_m = c;
      if (lat_1 == 0 && ov_1)      lat_1 = c;
      if (lat_8 == 0 && ov_8)      lat_8 = c;
    end
    check("latency K8 S4", lat_m, 32'd2);
    check("latency K8 S8", lat_1, 32'd1);
    check("latency K32 S4", lat_8, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
